// File: rtl/stream_mux_4to1.sv
// Four-input packet-granular round-robin merge onto one registered valid/ready stream.
// Each output beat carries the index of the input it came from.
module stream_mux_4to1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready,
  output logic               locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t       state, state_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic [1:0]   lock_sel, lock_sel_nxt;
  logic [1:0]   grant_sel;
  logic [1:0]   idx;
  logic         grant_any;
  logic         can_load;
  logic         accept;
  logic         acc_last;
  logic [WIDTH-1:0] acc_data;

  // Grant selection: locked input while mid-packet, otherwise first valid from ptr.
  always_comb begin
    grant_sel = lock_sel;
    grant_any = 1'b0;
    idx       = '0;
    if (state == LOCKED) begin
      grant_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!grant_any && in_valid[idx]) begin
          grant_any = 1'b1;
          grant_sel = idx;
        end
      end
    end
  end

  assign can_load = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (rst_n && grant_any && can_load) in_ready[grant_sel] = 1'b1;
  end

  assign accept   = in_valid[grant_sel] && in_ready[grant_sel];
  assign acc_last = in_last[grant_sel];
  assign acc_data = in_data[int'(grant_sel)*WIDTH +: WIDTH];

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_sel_nxt = lock_sel;
    if (accept) begin
      if (acc_last) begin
        state_nxt = IDLE;
        ptr_nxt   = grant_sel + 2'd1;
      end else begin
        state_nxt    = LOCKED;
        lock_sel_nxt = grant_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_sel  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_sel <= lock_sel_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_last  <= acc_last;
        out_data  <= acc_data;
        out_sel   <= grant_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_stream_mux_4to1.sv
// Randomized and directed bench for stream_mux_4to1 against a cycle-level reference model.
module tb_stream_mux_4to1;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         in_valid, in_last, in_ready;
  logic [4*WIDTH-1:0] in_data;
  logic               out_valid, out_last, out_ready, locked;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  stream_mux_4to1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready), .locked(locked)
  );

  // Source side: per-input beat queues {last, data}; a presented beat is held until accepted.
  logic [WIDTH:0] src_q [4][$];
  bit             present [4];
  int             valid_pct = 100;
  int             force_ready = 1;

  // Reference model state; m_lock = -1 means no packet in progress.
  bit             m_ov, m_ol;
  logic [7:0]     m_od;
  int             m_os, m_ptr, m_lock;

  // Transferred beats seen at the output: {last, sel, data} and the cycle they left.
  logic [10:0]    out_log [$];
  int             out_cyc [$];
  logic [10:0]    exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_ol = 0; m_od = '0; m_os = 0; m_ptr = 0; m_lock = -1;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      present[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (!present[i] && src_q[i].size() > 0 && $urandom_range(99) < valid_pct) present[i] = 1;
      in_valid[i] = present[i];
      if (present[i]) begin
        in_data[i*WIDTH +: WIDTH] = src_q[i][0][WIDTH-1:0];
        in_last[i]                = src_q[i][0][WIDTH];
      end else begin
        in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        in_last[i]                = 1'($urandom);
      end
    end
    out_ready = (force_ready >= 0) ? force_ready[0] : ($urandom_range(99) < 70);
  endtask

  task automatic step();
    logic [3:0] exp_ready;
    bit         can;
    int         win;
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    check_val("out_valid", out_valid, m_ov);
    check_val("out_data", out_data, m_od);
    check_val("out_last", out_last, m_ol);
    check_val("out_sel", out_sel, m_os);
    check_val("locked", locked, m_lock >= 0);
    if (out_valid && out_ready) begin
      out_log.push_back({out_last, out_sel, out_data});
      out_cyc.push_back(cyc);
    end
    exp_ready = '0;
    can = !m_ov || out_ready;
    win = -1;
    if (m_lock >= 0) begin
      win = m_lock;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && in_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      end
    end
    if (win >= 0 && can) exp_ready[win] = 1'b1;
    check_val("in_ready", in_ready, exp_ready);
    if (win >= 0 && exp_ready[win] && in_valid[win]) begin
      m_ov = 1; m_od = in_data[win*WIDTH +: WIDTH]; m_ol = in_last[win]; m_os = win;
      if (in_last[win]) begin
        m_lock = -1;
        m_ptr  = (win + 1) % 4;
      end else begin
        m_lock = win;
      end
      void'(src_q[win].pop_front());
      present[win] = 0;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    in_valid  = 4'($urandom);
    in_last   = 4'($urandom);
    in_data   = 32'($urandom);
    out_ready = 1'($urandom);
    model_reset();
    #1;
    check_val("rst_in_ready", in_ready, 4'b0000);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sel", out_sel, 0);
    check_val("rst_locked", locked, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready_hold", in_ready, 4'b0000);
    in_valid = '0;
    rst_n = 1'b1;
    out_log.delete();
    out_cyc.delete();
  endtask

  function automatic bit busy();
    busy = m_ov;
    for (int i = 0; i < 4; i++) if (src_q[i].size() > 0) busy = 1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check_val("drain_idle", busy(), 0);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_count"}, out_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      check_val(tag, out_log[i], exp_q[i]);
      if (i > 0) check_val({tag, "_gap"}, out_cyc[i] - out_cyc[i-1], 1);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    model_reset();

    // Reset and idle.
    do_reset();
    repeat (3) step();

    // Lone two-beat packet on input 2.
    src_q[2].push_back({1'b0, 8'hA1});
    src_q[2].push_back({1'b1, 8'hA2});
    drain(20);
    exp_q = '{{1'b0, 2'd2, 8'hA1}, {1'b1, 2'd2, 8'hA2}};
    check_log("t2_seq");

    // All inputs contending with single-beat packets.
    do_reset();
    src_q[0].push_back({1'b1, 8'h00}); src_q[0].push_back({1'b1, 8'h04});
    src_q[1].push_back({1'b1, 8'h01}); src_q[1].push_back({1'b1, 8'h05});
    src_q[2].push_back({1'b1, 8'h02});
    src_q[3].push_back({1'b1, 8'h03});
    drain(30);
    exp_q = '{{1'b1, 2'd0, 8'h00}, {1'b1, 2'd1, 8'h01}, {1'b1, 2'd2, 8'h02},
              {1'b1, 2'd3, 8'h03}, {1'b1, 2'd0, 8'h04}, {1'b1, 2'd1, 8'h05}};
    check_log("t3_rr");

    // Locked three-beat packet on input 1 blocks input 0.
    do_reset();
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h12});
    src_q[1].push_back({1'b1, 8'h13});
    step();
    src_q[0].push_back({1'b1, 8'h01});
    drain(30);
    exp_q = '{{1'b0, 2'd1, 8'h11}, {1'b0, 2'd1, 8'h12}, {1'b1, 2'd1, 8'h13}, {1'b1, 2'd0, 8'h01}};
    check_log("t4_lock");

    // Output stall holds the register and blocks all inputs.
    do_reset();
    src_q[0].push_back({1'b1, 8'h5C});
    src_q[1].push_back({1'b1, 8'h77});
    force_ready = 0;
    step();
    repeat (3) begin
      step();
      check_val("t5_stall_data", out_data, 8'h5C);
      check_val("t5_stall_ready", in_ready, 4'b0000);
    end
    force_ready = 1;
    step();
    step();
    check_val("t5_next_data", out_data, 8'h77);
    check_val("t5_next_sel", out_sel, 1);
    drain(20);

    // Reset mid-packet on input 3.
    do_reset();
    src_q[3].push_back({1'b0, 8'h31});
    src_q[3].push_back({1'b0, 8'h32});
    src_q[3].push_back({1'b1, 8'h33});
    step();
    step();
    check_val("t6_locked_mid", locked, 1);
    do_reset();
    src_q[0].push_back({1'b1, 8'h0A});
    src_q[3].push_back({1'b1, 8'h3A});
    drain(20);
    exp_q = '{{1'b1, 2'd0, 8'h0A}, {1'b1, 2'd3, 8'h3A}};
    check_log("t6_after_rst");

    // Randomized traffic with random valid gaps and backpressure.
    valid_pct   = 60;
    force_ready = -1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(99) < 30) begin
          int len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++)
            src_q[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      step();
    end
    drain(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
